window_bit_counter: RTL and testbench
=====================================

# window_bit_counter

Parametrised multi-channel bit-stream counter, successor to the single-channel ones counter in the sequence-detecting FSM datapath. Counts events on NCH test-bit lanes over a window bounded by the LFSR `max_tick`, snapshots all lane counts into a result register at each window end, and delivers the snapshot downstream through a valid/ready handshake. Adds selectable event modes, saturation, per-lane overflow flags and dropped-result signalling.

## Interface
- `NCH`, 4, number of independent bit lanes (≥1)
- `WIDTH`, 16, counter width per lane (≥2)
- `SATURATE`, 1, 1 = counters clamp at all-ones; 0 = counters wrap modulo 2^WIDTH

- `clk`  in  1  single clock, rising edge
- `reset_n`  in  1  synchronous, active-low reset
- `enable`  in  1  1 = sample `test_bits` this cycle
- `window_end`  in  1  LFSR `max_tick`; closes the current window
- `test_bits`  in  NCH  one bit per lane
- `count_mode`  in  2  00 ones, 01 zeros, 10 rising edges (0→1), 11 any transition
- `live_count`  out  NCH*WIDTH  running counts, lane i at [i*WIDTH +: WIDTH]
- `result`  out  NCH*WIDTH  snapshot of the last closed window, same packing
- `result_ovf`  out  NCH  per-lane overflow flag of the snapshotted window
- `result_valid`  out  1  snapshot available
- `result_ready`  in  1  consumer accepts snapshot
- `result_dropped`  out  1  one-cycle pulse: unconsumed snapshot overwritten

## Operation
- Per lane, event `ev[i]` when `enable`=1: mode 00 `bit`; 01 `~bit`; 10 `bit & ~prev[i]`; 11 `bit ^ prev[i]`. `ev`=0 when `enable`=0.
- `prev[NCH-1:0]` loads `test_bits` on every cycle with `enable`=1, holds otherwise; reset value 0. `prev` is not cleared at window end (edges spanning a boundary count in the new window).
- Next count `nxt[i] = live[i] + ev[i]`. If `live[i]` is all-ones and `ev[i]`=1: SATURATE=1 → `nxt` stays all-ones; SATURATE=0 → `nxt` = 0. In both cases lane overflow flag `ovf[i]` sets, sticky until window end.
- `window_end`=1 (honoured regardless of `enable`): `result` ← `nxt` (the current cycle's event is included in the closing window); `result_ovf` ← `ovf | this-cycle overflow`; `live` ← 0; `ovf` ← 0; `result_valid` ← 1.
- `window_end`=0: `live` ← `nxt`, `ovf` accumulates.
- Handshake: snapshot is consumed on a cycle with `result_valid`=1 and `result_ready`=1; `result_valid` clears next cycle unless `window_end` occurs in that same cycle, in which case the new snapshot loads, `result_valid` stays 1, and there is no drop pulse.
- Drop: `window_end`=1 while `result_valid`=1 and `result_ready`=0 → new snapshot overwrites, `result_valid` stays 1, `result_dropped`=1 for the next cycle only.
- `result` and `result_ovf` are stable while `result_valid`=1 and no `window_end` occurs.
- `count_mode` changes take effect on the next sampled cycle; upstream changes it only together with `window_end`.

## Timing
- All outputs are registered; no combinational input→output path.
- Reset (`reset_n`=0 at a rising edge): `live_count`, `result`, `result_ovf`, `prev`, `ovf` = 0; `result_valid`=0; `result_dropped`=0. Reset mid-window discards the partial window without a snapshot; reset overrides `window_end`.
- Latency: event at edge k → `live_count` updated after edge k. `window_end` at edge k → `result`/`result_valid` visible after edge k, `live_count`=0 after edge k.
- Back-to-back `window_end` every cycle is legal: each cycle produces a one-sample snapshot.
- Throughput: one sample per lane per cycle, all lanes in parallel.

## Test plan
- Reset/ones: NCH=4, mode 00, lane0 held 1 for 10 enabled cycles, `window_end` on 10th → `result` lane0=10, others 0, `result_valid`=1, `live_count`=0.
- Edge modes: lane1 pattern 0,1,1,0,1,0 (prev 0), mode 10 → 2; mode 11 → 4; mode 01 → 3.
- Saturation: WIDTH=4, SATURATE=1, 20 ones → `result`=15, `result_ovf[0]`=1; SATURATE=0 → `result`=4, `result_ovf[0]`=1; next window's `ovf` starts at 0.
- Handshake: `result_ready`=0 over two `window_end`s → `result_dropped` pulses one cycle, `result` holds the second window; `result_ready`=1 with `window_end` same cycle → no drop, `result_valid` stays 1.
- Enable gating: `enable`=0 for 5 cycles with `test_bits`=all-ones → counts unchanged, `prev` held; `window_end` with `enable`=0 → snapshot excludes that cycle.
- Reset mid-window: count 7, drive `reset_n`=0 together with `window_end` → all outputs 0, `result_valid`=0.

Source files
------------

// File: rtl/window_bit_counter.sv
// Multi-lane windowed event counter. Lanes count events selected by count_mode,
// and each closed window is snapshotted into a result register with a valid/ready handshake.
module window_bit_counter #(
  parameter int NCH      = 4,
  parameter int WIDTH    = 16,
  parameter bit SATURATE = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic                   window_end,
  input  logic [NCH-1:0]         test_bits,
  input  logic [1:0]             count_mode,
  output logic [NCH*WIDTH-1:0]   live_count,
  output logic [NCH*WIDTH-1:0]   result,
  output logic [NCH-1:0]         result_ovf,
  output logic                   result_valid,
  input  logic                   result_ready,
  output logic                   result_dropped
);

  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

  logic [NCH*WIDTH-1:0] live_q, live_d;
  logic [NCH*WIDTH-1:0] result_q, result_d;
  logic [NCH-1:0]       result_ovf_q, result_ovf_d;
  logic [NCH-1:0]       ovf_q, ovf_d;
  logic [NCH-1:0]       prev_q, prev_d;
  logic                 result_valid_q, result_valid_d;
  logic                 result_dropped_q, result_dropped_d;

  logic [NCH-1:0]       ev;
  logic [NCH-1:0]       ovf_now;
  logic [NCH*WIDTH-1:0] nxt;
  logic [WIDTH-1:0]     lane;

  // Per-lane event selection and next count (wrap or clamp on all-ones).
  always_comb begin
    ev      = '0;
    ovf_now = '0;
    nxt     = '0;
    lane    = '0;
    for (int i = 0; i < NCH; i++) begin
      lane = live_q[i*WIDTH +: WIDTH];
      if (enable) begin
        case (count_mode)
          2'b00:   ev[i] = test_bits[i];
          2'b01:   ev[i] = ~test_bits[i];
          2'b10:   ev[i] = test_bits[i] & ~prev_q[i];
          default: ev[i] = test_bits[i] ^ prev_q[i];
        endcase
      end
      if (ev[i] && (lane == ALL_ONES)) begin
        ovf_now[i]            = 1'b1;
        nxt[i*WIDTH +: WIDTH] = SATURATE ? ALL_ONES : '0;
      end else begin
        nxt[i*WIDTH +: WIDTH] = lane + {{(WIDTH-1){1'b0}}, ev[i]};
      end
    end
  end

  // Handshake: a snapshot is held while result_valid=1 and transfers on any
  // cycle with result_valid=1 and result_ready=1. A window_end in that same
  // cycle reloads immediately (valid stays high, no drop); a window_end while
  // valid=1 and ready=0 overwrites and pulses result_dropped for one cycle.
  always_comb begin
    live_d           = nxt;
    ovf_d            = ovf_q | ovf_now;
    prev_d           = enable ? test_bits : prev_q;
    result_d         = result_q;
    result_ovf_d     = result_ovf_q;
    result_valid_d   = result_valid_q;
    result_dropped_d = 1'b0;
    if (window_end) begin
      result_d         = nxt;
      result_ovf_d     = ovf_q | ovf_now;
      live_d           = '0;
      ovf_d            = '0;
      result_valid_d   = 1'b1;
      result_dropped_d = result_valid_q & ~result_ready;
    end else if (result_valid_q && result_ready) begin
      result_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      live_q           <= '0;
      result_q         <= '0;
      result_ovf_q     <= '0;
      ovf_q            <= '0;
      prev_q           <= '0;
      result_valid_q   <= 1'b0;
      result_dropped_q <= 1'b0;
    end else begin
      live_q           <= live_d;
      result_q         <= result_d;
      result_ovf_q     <= result_ovf_d;
      ovf_q            <= ovf_d;
      prev_q           <= prev_d;
      result_valid_q   <= result_valid_d;
      result_dropped_q <= result_dropped_d;
    end
  end

  assign live_count     = live_q;
  assign result         = result_q;
  assign result_ovf     = result_ovf_q;
  assign result_valid   = result_valid_q;
  assign result_dropped = result_dropped_q;

endmodule

// File: tb/tb_window_bit_counter.sv
// Bench for window_bit_counter: a saturating and a wrapping instance share stimulus
// and are checked every cycle against an integer window model, plus literal expectations.
module tb_window_bit_counter;

  localparam int NCH  = 4;
  localparam int W    = 4;
  localparam int MAXV = (1 << W) - 1;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic enable = 1'b0;
  logic window_end = 1'b0;
  logic [NCH-1:0] test_bits = '0;
  logic [1:0] count_mode = 2'b00;
  logic result_ready = 1'b0;

  logic [NCH*W-1:0] live_s, res_s, live_w, res_w;
  logic [NCH-1:0]   rovf_s, rovf_w;
  logic             rv_s, rd_s, rv_w, rd_w;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  // clock / reset block
  always #5 clk = ~clk;

  window_bit_counter #(.NCH(NCH), .WIDTH(W), .SATURATE(1'b1)) dut_s (
    .clk(clk), .reset_n(reset_n), .enable(enable), .window_end(window_end),
    .test_bits(test_bits), .count_mode(count_mode), .live_count(live_s),
    .result(res_s), .result_ovf(rovf_s), .result_valid(rv_s),
    .result_ready(result_ready), .result_dropped(rd_s));

  window_bit_counter #(.NCH(NCH), .WIDTH(W), .SATURATE(1'b0)) dut_w (
    .clk(clk), .reset_n(reset_n), .enable(enable), .window_end(window_end),
    .test_bits(test_bits), .count_mode(count_mode), .live_count(live_w),
    .result(res_w), .result_ovf(rovf_w), .result_valid(rv_w),
    .result_ready(result_ready), .result_dropped(rd_w));

  // Window model: index 0 = saturating instance, 1 = wrapping instance.
  int m_live[2][NCH];
  int m_res[2][NCH];
  bit m_ovf[2][NCH];
  bit m_rovf[2][NCH];
  bit m_prev[NCH];
  bit m_valid, m_drop;

  always @(posedge clk) begin
    if (!reset_n) begin
      for (int s = 0; s < 2; s++)
        for (int l = 0; l < NCH; l++) begin
          m_live[s][l] = 0; m_res[s][l] = 0; m_ovf[s][l] = 0; m_rovf[s][l] = 0;
        end
      for (int l = 0; l < NCH; l++) m_prev[l] = 0;
      m_valid = 0; m_drop = 0;
    end else begin
      for (int l = 0; l < NCH; l++) begin
        int e;
        bit b;
        b = test_bits[l];
        e = 0;
        if (enable) begin
          if (count_mode == 2'd0) e = b ? 1 : 0;
          else if (count_mode == 2'd1) e = b ? 0 : 1;
          else if (count_mode == 2'd2) e = (b && !m_prev[l]) ? 1 : 0;
          else e = (b != m_prev[l]) ? 1 : 0;
        end
        for (int s = 0; s < 2; s++) begin
          int n;
          bit ov;
          n = m_live[s][l] + e;
          ov = 0;
          if (n > MAXV) begin
            ov = 1;
            n = (s == 0) ? MAXV : n - (MAXV + 1);
          end
          if (window_end) begin
            m_res[s][l] = n; m_rovf[s][l] = m_ovf[s][l] | ov;
            m_live[s][l] = 0; m_ovf[s][l] = 0;
          end else begin
            m_live[s][l] = n; m_ovf[s][l] = m_ovf[s][l] | ov;
          end
        end
      end
      m_drop = window_end && m_valid && !result_ready;
      if (window_end) m_valid = 1;
      else if (result_ready) m_valid = 0;
      if (enable) for (int l = 0; l < NCH; l++) m_prev[l] = test_bits[l];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard compare, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      for (int s = 0; s < 2; s++) begin
        logic [NCH*W-1:0] el, er;
        logic [NCH-1:0] eo;
        for (int l = 0; l < NCH; l++) begin
          el[l*W +: W] = m_live[s][l][W-1:0];
          er[l*W +: W] = m_res[s][l][W-1:0];
          eo[l] = m_rovf[s][l];
        end
        check(s == 0 ? "sat_live" : "wrap_live", 32'(s == 0 ? live_s : live_w), 32'(el));
        check(s == 0 ? "sat_result" : "wrap_result", 32'(s == 0 ? res_s : res_w), 32'(er));
        check(s == 0 ? "sat_ovf" : "wrap_ovf", 32'(s == 0 ? rovf_s : rovf_w), 32'(eo));
        check(s == 0 ? "sat_valid" : "wrap_valid", 32'(s == 0 ? rv_s : rv_w), 32'(m_valid));
        check(s == 0 ? "sat_dropped" : "wrap_dropped", 32'(s == 0 ? rd_s : rd_w), 32'(m_drop));
      end
    end
  end

  // driver: present one cycle of inputs, return 1ns after the edge
  task automatic step(input logic en, input logic we, input logic [NCH-1:0] bits,
                      input logic [1:0] mode, input logic rdy);
    enable = en; window_end = we; test_bits = bits; count_mode = mode; result_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic run_ones(input int n, input logic [NCH-1:0] bits, input logic [1:0] mode,
                          input logic rdy_last);
    for (int i = 0; i < n; i++)
      step(1'b1, i == n - 1, bits, mode, (i == n - 1) ? rdy_last : 1'b0);
  endtask

  logic [5:0] pat;

  initial begin
    reset_n = 1'b0;
    repeat (3) step(1'b0, 1'b0, '0, 2'b00, 1'b0);
    chk_en = 1'b1;
    check("reset_valid", 32'(rv_s), 32'h0);
    check("reset_live", 32'(live_s), 32'h0);
    check("reset_result", 32'(res_w), 32'h0);
    reset_n = 1'b1;

    // ones: lane0 high for 10 enabled cycles
    run_ones(10, 4'b0001, 2'b00, 1'b0);
    check("ones_result", 32'(res_s), 32'h000A);
    check("ones_valid", 32'(rv_s), 32'h1);
    check("ones_live", 32'(live_s), 32'h0);
    step(1'b0, 1'b0, '0, 2'b00, 1'b1);
    check("consume_valid", 32'(rv_s), 32'h0);

    // edge modes on lane1 pattern 0,1,1,0,1,0
    pat = 6'b010110;
    for (int m = 0; m < 3; m++) begin
      logic [1:0] md;
      md = (m == 0) ? 2'b10 : (m == 1) ? 2'b11 : 2'b01;
      step(1'b0, 1'b1, '0, md, 1'b1);
      for (int i = 0; i < 6; i++)
        step(1'b1, i == 5, {2'b00, pat[i], 1'b0}, md, 1'b0);
      if (m == 0) check("mode_rise", 32'(res_s), 32'h0020);
      if (m == 1) check("mode_toggle", 32'(res_s), 32'h0040);
      if (m == 2) check("mode_zeros", 32'(res_s), 32'h6636);
    end

    // saturation / wrap: 20 ones on lane0, then a short clean window
    step(1'b0, 1'b1, '0, 2'b00, 1'b1);
    run_ones(20, 4'b0001, 2'b00, 1'b1);
    check("sat_res15", 32'(res_s), 32'h000F);
    check("sat_ovf0", 32'(rovf_s), 32'h1);
    check("wrap_res4", 32'(res_w), 32'h0004);
    check("wrap_ovf0", 32'(rovf_w), 32'h1);
    run_ones(3, 4'b0001, 2'b00, 1'b1);
    check("next_win_ovf", 32'(rovf_s), 32'h0);
    check("next_win_res", 32'(res_w), 32'h0003);

    // handshake: two window_ends unconsumed, then same-cycle consume+reload
    step(1'b0, 1'b0, '0, 2'b00, 1'b1);
    run_ones(2, 4'b0010, 2'b00, 1'b0);
    check("hs_first_drop", 32'(rd_s), 32'h0);
    run_ones(3, 4'b0100, 2'b00, 1'b0);
    check("hs_drop_pulse", 32'(rd_s), 32'h1);
    check("hs_second_res", 32'(res_s), 32'h0300);
    step(1'b0, 1'b0, '0, 2'b00, 1'b0);
    check("hs_drop_clear", 32'(rd_w), 32'h0);
    check("hs_hold_res", 32'(res_w), 32'h0300);
    step(1'b1, 1'b1, 4'b1000, 2'b00, 1'b1);
    check("hs_reload_valid", 32'(rv_s), 32'h1);
    check("hs_reload_nodrop", 32'(rd_s), 32'h0);
    check("hs_reload_res", 32'(res_s), 32'h1000);

    // enable gating: disabled all-ones cycles must not count nor load prev
    step(1'b0, 1'b0, '0, 2'b00, 1'b1);
    step(1'b1, 1'b0, 4'b0001, 2'b00, 1'b0);
    step(1'b1, 1'b0, 4'b0001, 2'b00, 1'b0);
    repeat (5) step(1'b0, 1'b0, 4'b1111, 2'b00, 1'b0);
    check("gate_live", 32'(live_s), 32'h0002);
    step(1'b0, 1'b1, 4'b1111, 2'b11, 1'b1);
    check("gate_we_res", 32'(res_s), 32'h0002);
    step(1'b1, 1'b1, 4'b1111, 2'b11, 1'b1);
    check("gate_prev_held", 32'(res_s), 32'h1110);
    step(1'b1, 1'b1, 4'b0000, 2'b11, 1'b1);
    check("b2b_res", 32'(res_w), 32'h1111);

    // reset mid-window overrides window_end
    step(1'b0, 1'b1, '0, 2'b00, 1'b1);
    repeat (7) step(1'b1, 1'b0, 4'b0001, 2'b00, 1'b1);
    check("pre_reset_live", 32'(live_s), 32'h0007);
    reset_n = 1'b0;
    step(1'b1, 1'b1, 4'b0001, 2'b00, 1'b1);
    check("rst_live", 32'(live_s), 32'h0);
    check("rst_result", 32'(res_s), 32'h0);
    check("rst_valid", 32'(rv_w), 32'h0);
    reset_n = 1'b1;
    step(1'b0, 1'b0, '0, 2'b00, 1'b0);
    step(1'b0, 1'b0, '0, 2'b00, 1'b0);

    @(posedge clk);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
